// File: rtl/bus_pkg.sv
// Shared bus definitions: arbiter state encoding, bus control bit positions, width helper.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package bus_pkg;

  // One-hot arbiter states
  typedef enum logic [2:0] {
    IDLE  = 3'b001,
    GRANT = 3'b010,
    TURN  = 3'b100
  } arb_state_t;

  // Bus control word bit positions, shared with the biu master/slave
  localparam int CTRL_RNW        = 1;
  localparam int CTRL_DATA_VALID = 0;

  // Bits needed to index n items, never less than one
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first requester at or after ptr, wrapping N-1 -> 0.
// Latency: purely combinational.
// Backpressure: none; result follows i_req/i_ptr directly.
module rr_pick #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] i_req,
  input  logic [W-1:0] i_ptr,
  output logic [N-1:0] o_gnt,
  output logic [W-1:0] o_idx,
  output logic         o_any
);

  // Two passes: indices from ptr upward first, then the wrapped-around low indices
  always_comb begin
    o_gnt = '0;
    o_idx = '0;
    o_any = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!o_any && i_req[i] && (i >= int'(i_ptr))) begin
        o_any    = 1'b1;
        o_gnt[i] = 1'b1;
        o_idx    = W'(i);
      end
    end
    for (int i = 0; i < N; i++) begin
      if (!o_any && i_req[i] && (i < int'(i_ptr))) begin
        o_any    = 1'b1;
        o_gnt[i] = 1'b1;
        o_idx    = W'(i);
      end
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Shared tri-state bus arbiter: round-robin, whole-transaction grants, idle turnaround, watchdog.
// Latency: grant registered one cycle after request seen in IDLE; drops one cycle after release/timeout.
// Backpressure: none; masters hold i_req until served, non-owner requests only sampled in IDLE.
module bus_arbiter
  import bus_pkg::*;
#(
  parameter  int NUM_MASTERS    = 4,
  parameter  int TURNAROUND     = 1,
  parameter  int TIMEOUT_CYCLES = 256,
  localparam int OWNER_W        = clog2_min1(NUM_MASTERS)
) (
  input  logic                   clk,
  input  logic                   n_rst,
  input  logic [NUM_MASTERS-1:0] i_req,
  output logic [NUM_MASTERS-1:0] o_gnt,
  output logic [OWNER_W-1:0]     o_owner,
  output logic                   o_busy,
  output logic                   o_timeout
);

  localparam int HOLD_W = clog2_min1(TIMEOUT_CYCLES + 1);
  localparam int TURN_W = clog2_min1(TURNAROUND);

  localparam logic [TURN_W-1:0]  TURN_LAST = TURN_W'(TURNAROUND - 1);
  localparam logic [OWNER_W-1:0] LAST_IDX  = OWNER_W'(NUM_MASTERS - 1);
  localparam logic [HOLD_W-1:0]  HOLD_MAX  = '1;

  arb_state_t             r_state;
  arb_state_t             w_state_nxt;
  logic [OWNER_W-1:0]     r_ptr;
  logic [OWNER_W-1:0]     r_owner;
  logic [OWNER_W-1:0]     w_owner_nxt;
  logic [NUM_MASTERS-1:0] r_gnt;
  logic [NUM_MASTERS-1:0] w_gnt_nxt;
  logic                   r_busy;
  logic                   w_busy_nxt;
  logic                   r_timeout;
  logic                   w_timeout_nxt;
  logic [HOLD_W-1:0]      r_hold;
  logic [TURN_W-1:0]      r_turn;

  logic [NUM_MASTERS-1:0] w_pick_gnt;
  logic [OWNER_W-1:0]     w_pick_idx;
  logic                   w_pick_any;
  logic                   w_owner_req;
  logic                   w_timeout_hit;
  logic                   w_release;

  rr_pick #(
    .N(NUM_MASTERS),
    .W(OWNER_W)
  ) u_pick (
    .i_req (i_req),
    .i_ptr (r_ptr),
    .o_gnt (w_pick_gnt),
    .o_idx (w_pick_idx),
    .o_any (w_pick_any)
  );

  // The current cycle is the last one the watchdog allows, so the grant drops on this edge
  assign w_owner_req   = i_req[r_owner];
  assign w_timeout_hit = (TIMEOUT_CYCLES != 0) && (int'(r_hold) >= TIMEOUT_CYCLES - 1);
  assign w_release     = w_timeout_hit || !w_owner_req;

  // State register
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state: grant on any request in IDLE, leave GRANT on release or watchdog, TURN is timed
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_pick_any) w_state_nxt = GRANT;
      GRANT:   if (w_release) w_state_nxt = TURN;
      TURN:    if (r_turn == TURN_LAST) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Next values of the registered outputs; owner index is kept while idle
  always_comb begin
    w_gnt_nxt     = r_gnt;
    w_owner_nxt   = r_owner;
    w_busy_nxt    = r_busy;
    w_timeout_nxt = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_pick_any) begin
          w_gnt_nxt   = w_pick_gnt;
          w_owner_nxt = w_pick_idx;
          w_busy_nxt  = 1'b1;
        end
      end
      GRANT: begin
        if (w_release) begin
          w_gnt_nxt     = '0;
          w_busy_nxt    = 1'b0;
          // Watchdog wins even if the owner released on the same cycle
          w_timeout_nxt = w_timeout_hit;
        end
      end
      default: begin
        w_gnt_nxt  = '0;
        w_busy_nxt = 1'b0;
      end
    endcase
  end

  // Output registers
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_gnt     <= '0;
      r_owner   <= '0;
      r_busy    <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_gnt     <= w_gnt_nxt;
      r_owner   <= w_owner_nxt;
      r_busy    <= w_busy_nxt;
      r_timeout <= w_timeout_nxt;
    end
  end

  // Round-robin pointer moves past the winner; hold and turnaround counters track state dwell
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_ptr  <= '0;
      r_hold <= '0;
      r_turn <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_pick_any) begin
            r_ptr  <= (w_pick_idx == LAST_IDX) ? '0 : w_pick_idx + OWNER_W'(1);
            r_hold <= '0;
          end
        end
        GRANT: begin
          if (r_hold != HOLD_MAX) r_hold <= r_hold + HOLD_W'(1);
          r_turn <= '0;
        end
        TURN: begin
          if (r_turn != TURN_LAST) r_turn <= r_turn + TURN_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign o_gnt     = r_gnt;
  assign o_owner   = r_owner;
  assign o_busy    = r_busy;
  assign o_timeout = r_timeout;

endmodule
